// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, falling-edge start
// detection, mid-bit sampling from a baud counter, optional parity, 1 or 2
// stop bits, and a valid/ready output holding stage with parity, framing
// and overrun reporting.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    // XOR over data and parity bit is 1 for a good odd frame, 0 for a good
    // even frame; flipping by this constant turns it into "mismatch".
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [IW-1:0]        idx, idx_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic                 perr, perr_d;
    logic                 ferr, ferr_d;

    logic sync1, sync2, hist;
    logic rx_s, fall, bit_tick;

    assign rx_s     = sync2;
    assign fall     = hist & ~sync2;
    assign bit_tick = (cnt == BIT_LAST);
    assign rx_busy  = (state != S_IDLE);

    // Synchroniser and edge history; reset to idle-high so a line held low
    // across reset still needs a genuine high-to-low transition... of the
    // synchronised value relative to the reset history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= rx_pin_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shift <= shift_d;
            perr  <= perr_d;
            ferr  <= ferr_d;
        end
    end

    // Next-state and datapath updates; counters only advance while below
    // their terminal value, so none can wrap inside a state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shift_d = shift;
        perr_d  = perr;
        ferr_d  = ferr;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift[DATA_BITS-1:1]};  // LSB arrives first
                    if (idx == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    perr_d  = (^{shift, rx_s}) ^ ODD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (!rx_s) ferr_d = 1'b1;
                    if (idx == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = ferr ? S_BREAK : S_IDLE;
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output holding stage: deliver in DONE unless an unaccepted word is
    // still held, in which case the new frame is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (state == S_DONE) begin
                if (!rx_valid || rx_ready) begin
                    rx_data       <= shift;
                    rx_parity_err <= perr;
                    rx_frame_err  <= ferr;
                    rx_valid      <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid      <= 1'b0;
                rx_parity_err <= 1'b0;
                rx_frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 7E1, 8N2) driven from
// a bit-level serial model; expected words and flags come from the frame
// contents, not from the receiver.
module tb_uart_rx_param;

    localparam int CPB = 16;

    int DB [3] = '{8, 7, 8};
    int PM [3] = '{0, 2, 0};
    int SB [3] = '{1, 1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic pin [3];
    logic rdy [3];
    logic vld [3];
    logic pe  [3];
    logic fe  [3];
    logic ov  [3];
    logic bsy [3];
    logic [7:0] d0, d2;
    logic [6:0] d1;

    int errs   = 0;
    int checks = 0;
    int ov_cnt [3];

    bit fr [$];
    logic [8:0] e_d;
    logic       e_p, e_f;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx_pin_in(pin[0]), .rx_data(d0), .rx_valid(vld[0]),
        .rx_ready(rdy[0]), .rx_parity_err(pe[0]), .rx_frame_err(fe[0]),
        .rx_overrun(ov[0]), .rx_busy(bsy[0]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rx_pin_in(pin[1]), .rx_data(d1), .rx_valid(vld[1]),
        .rx_ready(rdy[1]), .rx_parity_err(pe[1]), .rx_frame_err(fe[1]),
        .rx_overrun(ov[1]), .rx_busy(bsy[1]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx_pin_in(pin[2]), .rx_data(d2), .rx_valid(vld[2]),
        .rx_ready(rdy[2]), .rx_parity_err(pe[2]), .rx_frame_err(fe[2]),
        .rx_overrun(ov[2]), .rx_busy(bsy[2]));

    // Count overrun pulses per receiver, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (ov[i] === 1'b1) ov_cnt[i]++;
    end

    function automatic logic [8:0] dat(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {2'b0, d1};
            default: return {1'b0, d2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: builds the wire bit sequence and the word/flags a
    // correct receiver must report for it.
    task automatic mk_frame(input int i, input logic [8:0] data, input logic bad_par,
                            input logic [1:0] stop_low);
        logic [8:0] t;
        logic [1:0] s;
        int ones;
        bit good;
        fr.delete();
        fr.push_back(1'b0);
        t = data; ones = 0; e_d = '0;
        for (int b = 0; b < DB[i]; b++) begin
            fr.push_back(t[0]);
            ones += int'(t[0]);
            e_d |= 9'(t[0]) << b;
            t = t >> 1;
        end
        e_p = 1'b0;
        if (PM[i] != 0) begin
            good = (PM[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            fr.push_back(good ^ bad_par);
            e_p = bad_par;
        end
        e_f = 1'b0; s = stop_low;
        for (int k = 0; k < SB[i]; k++) begin
            fr.push_back(~s[0]);
            e_f |= s[0];
            s = s >> 1;
        end
    endtask

    // Drive the prepared frame; rx_ready pulses for one cycle at negedge rdy_at.
    task automatic frame(input int i, input logic [8:0] data, input logic bad_par,
                         input logic [1:0] stop_low, input int rdy_at, input logic tail);
        mk_frame(i, data, bad_par, stop_low);
        for (int k = 0; k < fr.size() * CPB; k++) begin
            @(negedge clk);
            pin[i] = fr[k / CPB];
            rdy[i] = (k == rdy_at);
        end
        @(negedge clk);
        pin[i] = tail;
        rdy[i] = 1'b0;
    endtask

    task automatic expect_word(input int i, input string tag);
        int n = 0;
        while (vld[i] !== 1'b1 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, 32'(vld[i]), 32'd1);
        chk({tag, "_data"}, 32'(dat(i)), 32'(e_d));
        chk({tag, "_perr"}, 32'(pe[i]), 32'(e_p));
        chk({tag, "_ferr"}, 32'(fe[i]), 32'(e_f));
    endtask

    task automatic accept(input int i, input string tag);
        @(negedge clk); rdy[i] = 1'b1;
        @(negedge clk); rdy[i] = 1'b0;
        chk({tag, "_acc_vld"}, 32'(vld[i]), 32'd0);
        chk({tag, "_acc_flags"}, 32'({pe[i], fe[i]}), 32'd0);
    endtask

    task automatic watch(input int i, input int n, output int vs, output int bs);
        vs = 0; bs = 0;
        repeat (n) begin
            @(negedge clk);
            vs += int'(vld[i] === 1'b1);
            bs += int'(bsy[i] === 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int vs, bs, vs2, bs2, base, done_k, ov_tot;
        logic [8:0]  rd;
        logic        rb;
        logic [1:0]  rs;
        for (int i = 0; i < 3; i++) begin
            pin[i] = 1'b1; rdy[i] = 1'b0; ov_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_vld%0d", i), 32'(vld[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("rst_data%0d", i), 32'(dat(i)), 32'd0);
            chk($sformatf("rst_flags%0d", i), 32'({pe[i], fe[i], ov[i]}), 32'd0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 word held until accepted
        frame(0, 9'h0A5, 1'b0, 2'b00, -1, 1'b1);
        expect_word(0, "a5");
        repeat (20) @(negedge clk);
        chk("a5_hold_vld", 32'(vld[0]), 32'd1);
        chk("a5_hold_data", 32'(dat(0)), 32'h0A5);
        accept(0, "a5");

        // 5-clock low glitch is a false start
        pin[0] = 1'b0;
        watch(0, 5, vs, bs);
        pin[0] = 1'b1;
        watch(0, 10, vs2, bs2);
        chk("glitch_busy_seen", 32'(bs > 0), 32'd1);
        chk("glitch_no_vld", 32'(vs + vs2), 32'd0);
        chk("glitch_idle", 32'(bsy[0]), 32'd0);
        chk("glitch_flags", 32'({pe[0], fe[0]}), 32'd0);

        // 7E1: bad then good parity on 0x35
        frame(1, 9'h035, 1'b1, 2'b00, -1, 1'b1);
        expect_word(1, "par_bad");
        accept(1, "par_bad");
        frame(1, 9'h035, 1'b0, 2'b00, -1, 1'b1);
        expect_word(1, "par_ok");
        accept(1, "par_ok");

        // 8N2: second stop low, then line held low
        frame(2, 9'h03C, 1'b0, 2'b10, -1, 1'b0);
        watch(2, 40, vs, bs);
        expect_word(2, "brk");
        accept(2, "brk");
        watch(2, 30, vs, bs);
        chk("brk_no_vld", 32'(vs), 32'd0);
        chk("brk_busy", 32'(bs), 32'd30);
        pin[2] = 1'b1;
        repeat (6) @(negedge clk);
        chk("brk_release_idle", 32'(bsy[2]), 32'd0);
        frame(2, 9'h05C, 1'b0, 2'b00, -1, 1'b1);
        expect_word(2, "brk_after");
        accept(2, "brk_after");

        // Overrun: second frame dropped while first is still held
        base = ov_cnt[0];
        frame(0, 9'h011, 1'b0, 2'b00, -1, 1'b1);
        frame(0, 9'h022, 1'b0, 2'b00, -1, 1'b1);
        repeat (4) @(negedge clk);
        chk("ovr_data", 32'(dat(0)), 32'h011);
        chk("ovr_vld", 32'(vld[0]), 32'd1);
        chk("ovr_pulses", 32'(ov_cnt[0] - base), 32'd1);
        accept(0, "ovr");

        // Same pair, but the held word is accepted on the DONE edge:
        // 2 sync + 1 into START + half-bit wait, remaining bits a period each.
        frame(0, 9'h011, 1'b0, 2'b00, -1, 1'b1);
        base = ov_cnt[0];
        done_k = 3 + CPB / 2 + (1 + DB[0] + SB[0] - 1) * CPB;
        frame(0, 9'h022, 1'b0, 2'b00, done_k, 1'b1);
        repeat (4) @(negedge clk);
        chk("swap_data", 32'(dat(0)), 32'h022);
        chk("swap_vld", 32'(vld[0]), 32'd1);
        chk("swap_no_ovr", 32'(ov_cnt[0] - base), 32'd0);

        // Reset during data bit 3 of 0xFF (word 0x22 still held)
        fork
            frame(0, 9'h0FF, 1'b0, 2'b00, -1, 1'b1);
            begin
                repeat (72) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("mid_rst_vld", 32'(vld[0]), 32'd0);
                chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
                chk("mid_rst_data", 32'(dat(0)), 32'd0);
                chk("mid_rst_flags", 32'({pe[0], fe[0], ov[0]}), 32'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 32'(bsy[0] | vld[0]), 32'd0);
        frame(0, 9'h05A, 1'b0, 2'b00, -1, 1'b1);
        expect_word(0, "post_rst");
        accept(0, "post_rst");

        // Randomised frames on all three receivers
        ov_tot = ov_cnt[0] + ov_cnt[1] + ov_cnt[2];
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) begin
                rd = 9'($urandom_range(0, 511));
                rb = (PM[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if (SB[i] == 1) rs = rs & 2'b01;
                frame(i, rd, rb, rs, -1, 1'b1);
                expect_word(i, $sformatf("rnd%0d_%0d", r, i));
                accept(i, $sformatf("rnd%0d_%0d", r, i));
                repeat ($urandom_range(2, 12)) @(negedge clk);
            end
        end
        chk("rnd_no_ovr", 32'(ov_cnt[0] + ov_cnt[1] + ov_cnt[2] - ov_tot), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
